// File: rtl/soc_pio_in_pkg.sv
// Shared constants for the input PIO: register addresses, edge-type encodings
// and the warm-up counter width helper.
package soc_pio_in_pkg;

   typedef enum logic [1:0] {
      ADDR_DATA    = 2'd0,
      ADDR_RSVD    = 2'd1,
      ADDR_IRQMASK = 2'd2,
      ADDR_EDGECAP = 2'd3
   } pio_addr_e;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // Counter must hold 0..stages+1 inclusive.
   function automatic int warmup_w(input int stages);
      return $clog2(stages + 2);
   endfunction

endpackage

// File: rtl/soc_pio_in_capture_if.sv
// Avalon-MM slave bus bundle for the input PIO (address, strobes, data).
interface soc_pio_in_capture_if #(
   parameter int WIDTH = 32
);
   logic [1:0]       address;
   logic             chipselect;
   logic             read_n;
   logic             write_n;
   logic [WIDTH-1:0] writedata;
   logic [WIDTH-1:0] readdata;

   modport master (
      output address, chipselect, read_n, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, read_n, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/soc_pio_in_sync.sv
// Input synchronizer, previous-sample register and warm-up gated edge detector.
module soc_pio_in_sync
   import soc_pio_in_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int EDGE_TYPE   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] edge_o
);

   localparam int CW = warmup_w(SYNC_STAGES);
   localparam logic [CW-1:0] WU_DONE = CW'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] chain_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;
   logic [CW-1:0]    wu_q, wu_d;
   logic [WIDTH-1:0] raw_edge;

   assign wu_d = (wu_q == WU_DONE) ? wu_q : wu_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) chain_q[i] <= '0;
         prev_q <= '0;
         wu_q   <= '0;
      end else begin
         chain_q[0] <= in_port_i;
         for (int i = 1; i < SYNC_STAGES; i++) chain_q[i] <= chain_q[i-1];
         prev_q <= chain_q[SYNC_STAGES-1];
         wu_q   <= wu_d;
      end
   end

   assign sync_o = chain_q[SYNC_STAGES-1];

   generate
      if (EDGE_TYPE == EDGE_FALL) begin : g_fall
         assign raw_edge = ~sync_o & prev_q;
      end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
         assign raw_edge = sync_o ^ prev_q;
      end else begin : g_rise
         assign raw_edge = sync_o & ~prev_q;
      end
   endgenerate

   // Suppress edges until the chain and prev register hold real input samples.
   assign edge_o = (wu_q == WU_DONE) ? raw_edge : '0;

endmodule

// File: rtl/soc_pio_in_capture.sv
// Avalon-MM input PIO with per-bit edge capture (RW1C) and masked level irq.
// Optional macro SOC_PIO_IN_IRQ_REG_EN registers irq (one extra cycle latency).
module soc_pio_in_capture
   import soc_pio_in_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int EDGE_TYPE   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   soc_pio_in_capture_if.slave bus,
   input  logic [WIDTH-1:0]    in_port,
   output logic                irq
);

   logic [WIDTH-1:0] sync_s, edge_s;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [WIDTH-1:0] clr;
   logic             wr_en, rd_en, irq_c;

   soc_pio_in_sync #(
      .WIDTH       (WIDTH),
      .EDGE_TYPE   (EDGE_TYPE),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_port_i (in_port),
      .sync_o    (sync_s),
      .edge_o    (edge_s)
   );

   always_comb begin
      wr_en  = bus.chipselect & ~bus.write_n;
      rd_en  = bus.chipselect & ~bus.read_n;
      clr    = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata : '0;
      // A new edge on a bit being cleared keeps the bit set.
      cap_d  = (cap_q & ~clr) | edge_s;
      mask_d = (wr_en && bus.address == ADDR_IRQMASK) ? bus.writedata : mask_q;
      rdata_d = '0;
      if (rd_en) begin
         case (bus.address)
            ADDR_DATA:    rdata_d = sync_s;
            ADDR_IRQMASK: rdata_d = mask_q;
            ADDR_EDGECAP: rdata_d = cap_q;
            default:      rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mask_q  <= '0;
         cap_q   <= '0;
         rdata_q <= '0;
      end else begin
         mask_q  <= mask_d;
         cap_q   <= cap_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.readdata = rdata_q;
   assign irq_c        = |(cap_q & mask_q);

`ifdef SOC_PIO_IN_IRQ_REG_EN
   logic irq_q;

   always_ff @(posedge clk) begin
      if (!reset_n) irq_q <= 1'b0;
      else          irq_q <= irq_c;
   end

   assign irq = irq_q;
`else
   assign irq = irq_c;
`endif

endmodule

// File: doc/soc_pio_in_capture.md
Name: soc_pio_in_capture

Overview:
- Avalon-MM slave input PIO, the read-direction counterpart of the SoC output PIO.
- Synchronizes an external input bus and detects edges per bit.
- Latches detected edges into a write-1-to-clear capture register.
- Raises a level interrupt for enabled bits; sits on the HPS/Nios lightweight bus next to the output PIOs.

Parameters:
- WIDTH, 32, input port and data-register width (1..32).
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2, metastability flops on in_port (2..4).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset, sampled on posedge clk.
- address  in  2  word address.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  WIDTH  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  WIDTH  registered read data.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset: one clock, synchronous active-low reset (reset_n sampled on posedge clk). Clears sync chain, previous-sample reg, irqmask, edgecapture, readdata, warm-up counter; irq=0.
- Register map:
  - 0 data (RO): synchronized in_port.
  - 1 reserved: reads 0, writes ignored.
  - 2 irqmask (RW).
  - 3 edgecapture (RW1C).
- Sync: in_port passes SYNC_STAGES flops → s; p = s delayed one cycle.
- Edge detect: edge = s&~p (rising), ~s&p (falling), s^p (any).
- Warm-up: counter runs SYNC_STAGES+1 cycles after reset release. Edge detection is forced to 0 until it saturates, so inputs already high at reset do not produce false captures.
- Capture: edgecapture[i] <= (edgecapture[i] & ~clr[i]) | edge[i].
  - clr = writedata when chipselect & ~write_n & address==3, else 0.
  - Simultaneous edge and clear on the same bit: set wins (bit stays 1).
- irqmask: written when chipselect & ~write_n & address==2. Bits above WIDTH are ignored.
- irq = |(edgecapture & irqmask), combinational from registers.
  - Asserts the cycle after the capture flop sets.
  - Deasserts the cycle after a clearing write or a mask write.
- Read:
  - readdata is registered, read latency fixed at 1. readdata <= mux(address) when chipselect & ~read_n, else readdata <= 0.
  - A read does not clear edgecapture. Write and read in the same cycle are legal; the read returns the pre-write value.
- in_port → data latency: SYNC_STAGES cycles into s, visible on readdata the cycle after the read strobe.
- Reset mid-operation: all state returns to reset values on the next edge and the warm-up restarts. A pending irq drops in that same cycle.

Optional Feature:
- Macro SOC_PIO_IN_IRQ_REG_EN.
- Defined: irq is driven from a flop, adding 1 cycle of assert and deassert latency; the flop resets to 0.
- Undefined: irq is combinational as above.

Decomposition:
- Package soc_pio_in_pkg:
  - address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - EDGE_TYPE encodings EDGE_RISE/EDGE_FALL/EDGE_ANY;
  - warm-up count width helper.
- One sub-module soc_pio_in_sync: sync chain, previous-sample reg, warm-up counter, edge vector out. The top level holds the registers, read mux and irq.

Test Plan:
- Hold in_port=32'hFFFF_FFFF through reset and release → edgecapture reads 0 after 10 cycles; data reads FFFF_FFFF; irq=0.
- EDGE_TYPE=0, irqmask=32'h1, in_port bit0 0→1 → edgecapture=32'h1 and irq=1 within SYNC_STAGES+2 cycles. Write 32'h1 to addr 3 → irq=0 next cycle.
- Bit3 rising edge in the same cycle as a write of 32'h8 to addr 3 → edgecapture bit3 remains 1.
- EDGE_TYPE=2, toggle bit5 twice with irqmask=0 → edgecapture=32'h20 and irq stays 0. Write mask 32'h20 → irq=1 the next cycle.
- Read addr 1 → readdata=0. Read addr 0 with in_port=32'hA5A5_0F0F stable → readdata=A5A5_0F0F exactly one cycle after the strobe.
- Capture a bit with irq=1, then pulse reset_n low one cycle → irq=0, irqmask=0, edgecapture=0 afterwards. With SOC_PIO_IN_IRQ_REG_EN defined, irq rises one cycle later than without.
